// File: rtl/serial_add_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_pkg
// Description : Shared types and constants for the bit-serial adder controller.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_add_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_add_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_fa_cell.sv
`default_nettype none
// ============================================================================
// Module      : serial_fa_cell
// Description : Combinational 1-bit full adder shared across all operand bits.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_c;
    assign o_co = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder, LSB first, one bit per clock, with a
//               start/ready/busy/done handshake. Optional SERIAL_ADD_SUB_EN
//               adds a 'sub' input for a-b via inverted b and carry-in of 1.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int                 c_cnt_w    = $clog2(WIDTH) + 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    serial_add_state_t r_state;
    serial_add_state_t w_state_next;

    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-2:0]   r_s_sr;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_s_next;
    logic [WIDTH-1:0]   w_b_load;
    logic               w_c_load;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1; cin has no meaning in that mode.
    assign w_b_load = sub ? ~b : b;
    assign w_c_load = sub | cin;
`else
    assign w_b_load = b;
    assign w_c_load = cin;
`endif

    serial_fa_cell u_fa (
        .i_a  (r_a_sr[0]),
        .i_b  (r_b_sr[0]),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_co (w_c)
    );

    assign w_accept = start & ready;
    assign w_last   = (r_state == RUN) && (r_cnt == c_cnt_last);
    // Newest sum bit on top of the WIDTH-1 bits accumulated so far.
    assign w_s_next = {w_s, r_s_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                if (start) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == c_cnt_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                ready        = 1'b1;
                done         = 1'b1;
                w_state_next = start ? RUN : IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            sum     <= '0;
            cout    <= 1'b0;
        end else if (w_accept) begin
            r_a_sr  <= a;
            r_b_sr  <= w_b_load;
            r_carry <= w_c_load;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_a_sr  <= r_a_sr >> 1;
            r_b_sr  <= r_b_sr >> 1;
            r_s_sr  <= w_s_next[WIDTH-1:1];
            r_carry <= w_c;
            r_cnt   <= r_cnt + c_cnt_one;
            if (w_last) begin
                sum  <= w_s_next;
                cout <= w_c;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench: directed cases plus random traffic against
//               a latency/arithmetic model of the serial adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_add_ctrl;

    localparam int WIDTH = 8;
`ifdef SERIAL_ADD_SUB_EN
    localparam bit SUB_EN = 1'b1;
`else
    localparam bit SUB_EN = 1'b0;
`endif

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             cin   = 1'b0;
    logic             sub   = 1'b0;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;

    // Model: remaining RUN edges of the accepted op, and the visible results.
    int               m_left = 0;
    bit               m_done = 1'b0;
    logic [WIDTH-1:0] m_sum = '0;
    logic             m_cout = 1'b0;
    logic [WIDTH-1:0] m_pend_sum = '0;
    logic             m_pend_cout = 1'b0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_left = 0;
        m_done = 1'b0;
        m_sum  = '0;
        m_cout = 1'b0;
    endtask

    task automatic model_edge();
        logic [WIDTH:0]   r;
        logic [WIDTH-1:0] bb;
        logic             sb;
        bit               was_ready;
        if (!rst_n) begin
            model_reset();
        end else begin
            was_ready = (m_left == 0);
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_sum  = m_pend_sum;
                    m_cout = m_pend_cout;
                    m_done = 1'b1;
                end
            end
            if (was_ready && start) begin
                sb = SUB_EN && sub;
                bb = sb ? ~b : b;
                r  = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sb | cin)};
                {m_pend_cout, m_pend_sum} = r;
                m_left = WIDTH;
            end
        end
    endtask

    task automatic compare_all();
        chk("ready", {31'b0, ready}, {31'b0, (m_left == 0)});
        chk("busy",  {31'b0, busy},  {31'b0, (m_left > 0)});
        chk("done",  {31'b0, done},  {31'b0, m_done});
        chk("sum",   {{(32-WIDTH){1'b0}}, sum}, {{(32-WIDTH){1'b0}}, m_sum});
        chk("cout",  {31'b0, cout},  {31'b0, m_cout});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
        if (done === 1'b1) done_seen++;
    endtask

    // Steps until done is seen; n counts edges stepped, bc counts busy cycles.
    task automatic wait_done(input int bound, output int n, output int bc);
        bit seen;
        seen = 1'b0;
        n = 0;
        bc = 0;
        for (int i = 0; i < bound && !seen; i++) begin
            step();
            n++;
            if (busy === 1'b1) bc++;
            if (done === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
        end
    endtask

    task automatic do_op(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic tc, input logic ts,
                         input logic [WIDTH-1:0] es, input logic ec);
        int n;
        int bc;
        a = ta; b = tb_; cin = tc; sub = ts; start = 1'b1;
        step();
        start = 1'b0;
        wait_done(3 * WIDTH, n, bc);
        chk({name, "_sum"},     {{(32-WIDTH){1'b0}}, sum}, {{(32-WIDTH){1'b0}}, es});
        chk({name, "_cout"},    {31'b0, cout}, {31'b0, ec});
        chk({name, "_latency"}, n + 1, WIDTH + 1);
        chk({name, "_busy"},    bc + 1, WIDTH);
        step();
    endtask

    initial begin
        int n;
        int bc;
        int d0;

        model_reset();
        step();
        step();
        chk("reset_ready", {31'b0, ready}, 32'd1);
        chk("reset_busy",  {31'b0, busy},  32'd0);
        chk("reset_sum",   {24'b0, sum},   32'd0);
        rst_n = 1'b1;
        step();

        do_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0);
        do_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1);
        do_op("add_ff_00c", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);

        // A second start during RUN must be dropped; operand changes ignored.
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        a = 8'hF0; b = 8'h0F; start = 1'b1;
        step();
        chk("ign_ready_low", {31'b0, ready}, 32'd0);
        start = 1'b0; a = 8'h00; b = 8'h00;
        wait_done(3 * WIDTH, n, bc);
        chk("ign_sum",  {24'b0, sum},  32'h02);
        chk("ign_cout", {31'b0, cout}, 32'd0);
        step();

        // start held high: DONE re-accepts without passing through IDLE.
        d0 = done_seen;
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        step();
        wait_done(3 * WIDTH, n, bc);
        chk("b2b_sum1", {24'b0, sum}, 32'h30);
        a = 8'h7F; b = 8'h01;
        step();
        chk("b2b_no_gap", {31'b0, busy}, 32'd1);
        wait_done(3 * WIDTH, n, bc);
        chk("b2b_sum2",  {24'b0, sum},  32'h80);
        chk("b2b_cout2", {31'b0, cout}, 32'd0);
        start = 1'b0;
        step();
        chk("b2b_dones", done_seen - d0, 32'd2);

        // Asynchronous abort in the middle of an operation.
        d0 = done_seen;
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        chk("abort_busy", {31'b0, busy}, 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < WIDTH + 4; i++) step();
        chk("abort_no_done", done_seen - d0, 32'd0);
        do_op("post_abort", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        do_op("sub_10_01", 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1);
        do_op("sub_01_02", 8'h01, 8'h02, 1'b1, 1'b1, 8'hFF, 1'b0);
        do_op("sub0_add",  8'h01, 8'h02, 1'b1, 1'b0, 8'h04, 1'b0);
`endif

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 1) == 1);
            a     = WIDTH'($urandom);
            b     = WIDTH'($urandom);
            cin   = $urandom_range(0, 1) == 1;
            sub   = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 79) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                compare_all();
                step();
                rst_n = 1'b1;
            end
            step();
        end
        start = 1'b0;
        for (int i = 0; i < WIDTH + 4; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
